// File: rtl/fetch_regs.sv
// fetch_regs: PC / OldPC / IR / MDR / ALUOut state registers of the multicycle
// RV32I core, with misaligned-PC halt detection and cycle / fetch counters.
module fetch_regs #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_pc,
    input  logic             we_ir,
    input  logic [31:0]      pc_next,
    input  logic [31:0]      mem_rdata,
    input  logic [31:0]      alu_result,
    output logic [31:0]      pc,
    output logic [31:0]      old_pc,
    output logic [31:0]      instr,
    output logic [31:0]      mdr,
    output logic [31:0]      alu_out,
    output logic [6:0]       op,
    output logic [2:0]       funct3,
    output logic             funct7b5,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic             halted,
    output logic [31:0]      fault_pc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   pc_aligned_c;
    logic   running_c;

    assign pc_aligned_c = (pc_next[1:0] == 2'b00);
    assign running_c    = (state_q == RUN);

    // Run/halt state register; only reset leaves HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a misaligned PC write while running halts the core.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:  if (we_pc && !pc_aligned_c) state_d = HALT;
            HALT: state_d = HALT;
        endcase
    end

    assign halted = (state_q == HALT);

    // Datapath registers and counters; enables are gated off while halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            old_pc    <= RESET_PC;
            instr     <= NOP_INSTR;
            mdr       <= 32'h0;
            alu_out   <= 32'h0;
            fault_pc  <= 32'h0;
            cycle_cnt <= '0;
            fetch_cnt <= '0;
        end else begin
            mdr     <= mem_rdata;
            alu_out <= alu_result;
            if (running_c) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
                if (we_ir) begin
                    // old_pc captures the pre-edge pc even when pc updates now
                    instr     <= mem_rdata;
                    old_pc    <= pc;
                    fetch_cnt <= fetch_cnt + CNT_W'(1);
                end
                if (we_pc) begin
                    if (pc_aligned_c) begin
                        pc <= pc_next;
                    end else begin
                        fault_pc <= pc_next;
                    end
                end
            end
        end
    end

    // Decode fields are plain slices of the instruction register.
    assign op       = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7b5 = instr[30];

endmodule

// File: tb/tb_fetch_regs.sv
// Directed bench for fetch_regs: vector table plus reset/recovery/wrap sequences.
module tb_fetch_regs;

    logic        clk;
    logic        rst;
    logic        we_pc;
    logic        we_ir;
    logic [31:0] pc_next;
    logic [31:0] mem_rdata;
    logic [31:0] alu_result;

    logic [31:0] pc, old_pc, instr, mdr, alu_out, fault_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5, halted;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] cycle_cnt, fetch_cnt;

    logic [31:0] pc4, old_pc4, instr4, mdr4, alu_out4, fault_pc4;
    logic [6:0]  op4;
    logic [2:0]  funct34;
    logic        funct7b54, halted4;
    logic [4:0]  rd4, rs14, rs24;
    logic [3:0]  cycle_cnt4, fetch_cnt4;

    int n_pass  = 0;
    int n_total = 0;

    fetch_regs dut (
        .clk(clk), .rst(rst), .we_pc(we_pc), .we_ir(we_ir),
        .pc_next(pc_next), .mem_rdata(mem_rdata), .alu_result(alu_result),
        .pc(pc), .old_pc(old_pc), .instr(instr), .mdr(mdr), .alu_out(alu_out),
        .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .halted(halted), .fault_pc(fault_pc),
        .cycle_cnt(cycle_cnt), .fetch_cnt(fetch_cnt)
    );

    fetch_regs #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .we_pc(we_pc), .we_ir(we_ir),
        .pc_next(pc_next), .mem_rdata(mem_rdata), .alu_result(alu_result),
        .pc(pc4), .old_pc(old_pc4), .instr(instr4), .mdr(mdr4), .alu_out(alu_out4),
        .op(op4), .funct3(funct34), .funct7b5(funct7b54),
        .rd(rd4), .rs1(rs14), .rs2(rs24),
        .halted(halted4), .fault_pc(fault_pc4),
        .cycle_cnt(cycle_cnt4), .fetch_cnt(fetch_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we_pc;
        logic        we_ir;
        logic [31:0] pc_next;
        logic [31:0] mem_rdata;
        logic [31:0] alu_result;
        logic [31:0] exp_pc;
        logic [31:0] exp_old_pc;
        logic [31:0] exp_instr;
        logic        exp_halted;
        logic [31:0] exp_fault_pc;
        logic [31:0] exp_cycle;
        logic [31:0] exp_fetch;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(logic wp, logic wi, logic [31:0] pn, logic [31:0] md,
                                logic [31:0] ar, logic [31:0] epc, logic [31:0] eopc,
                                logic [31:0] ein, logic eh, logic [31:0] ef,
                                logic [31:0] ec, logic [31:0] efc);
        vec_t v;
        v.we_pc = wp; v.we_ir = wi; v.pc_next = pn; v.mem_rdata = md; v.alu_result = ar;
        v.exp_pc = epc; v.exp_old_pc = eopc; v.exp_instr = ein; v.exp_halted = eh;
        v.exp_fault_pc = ef; v.exp_cycle = ec; v.exp_fetch = efc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wp, input logic wi, input logic [31:0] pn,
                         input logic [31:0] md, input logic [31:0] ar);
        we_pc = wp; we_ir = wi; pc_next = pn; mem_rdata = md; alu_result = ar;
    endtask

    initial begin
        logic [31:0] ein;
        //          we_pc we_ir pc_next      mem_rdata    alu   pc        old_pc    instr        h  fault     cyc fetch
        vecs[0] = mk(1, 1, 32'h4,  32'h00500093, 32'h11, 32'h4,  32'h0,  32'h00500093, 0, 32'h0,  1, 1);
        vecs[1] = mk(1, 0, 32'h8,  32'hdeadbeef, 32'h22, 32'h8,  32'h0,  32'h00500093, 0, 32'h0,  2, 1);
        vecs[2] = mk(0, 0, 32'h23, 32'h1,        32'h2,  32'h8,  32'h0,  32'h00500093, 0, 32'h0,  3, 1);
        vecs[3] = mk(1, 0, 32'h20, 32'h00a00113, 32'h3,  32'h20, 32'h0,  32'h00500093, 0, 32'h0,  4, 1);
        vecs[4] = mk(1, 1, 32'h24, 32'h40208033, 32'h4,  32'h24, 32'h20, 32'h40208033, 0, 32'h0,  5, 2);
        vecs[5] = mk(0, 1, 32'h0,  32'h00c0006f, 32'h5,  32'h24, 32'h24, 32'h00c0006f, 0, 32'h0,  6, 3);
        vecs[6] = mk(1, 1, 32'h22, 32'h12345678, 32'h6,  32'h24, 32'h24, 32'h12345678, 1, 32'h22, 7, 4);
        vecs[7] = mk(1, 1, 32'h40, 32'hcafef00d, 32'h7,  32'h24, 32'h24, 32'h12345678, 1, 32'h22, 7, 4);
        vecs[8] = mk(1, 0, 32'h33, 32'h0,        32'h8,  32'h24, 32'h24, 32'h12345678, 1, 32'h22, 7, 4);

        // Reset with random inputs, including enables.
        rst = 1'b1;
        drive(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
        step();
        drive(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_old_pc", old_pc, 32'h0);
        check("rst_instr", instr, 32'h13);
        check("rst_op", 32'(op), 32'h13);
        check("rst_mdr", mdr, 32'h0);
        check("rst_cycle", cycle_cnt, 32'h0);
        check("rst_fetch", fetch_cnt, 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_fault_pc", fault_pc, 32'h0);

        // Vector table: fetch, branch, hold, misaligned halt, ignored enables.
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].we_pc, vecs[i].we_ir, vecs[i].pc_next, vecs[i].mem_rdata,
                  vecs[i].alu_result);
            step();
            check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("v%0d_old_pc", i), old_pc, vecs[i].exp_old_pc);
            check($sformatf("v%0d_instr", i), instr, vecs[i].exp_instr);
            check($sformatf("v%0d_mdr", i), mdr, vecs[i].mem_rdata);
            check($sformatf("v%0d_alu_out", i), alu_out, vecs[i].alu_result);
            check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].exp_halted));
            check($sformatf("v%0d_fault_pc", i), fault_pc, vecs[i].exp_fault_pc);
            check($sformatf("v%0d_cycle", i), cycle_cnt, vecs[i].exp_cycle);
            check($sformatf("v%0d_fetch", i), fetch_cnt, vecs[i].exp_fetch);
            ein = vecs[i].exp_instr;
            check($sformatf("v%0d_op", i), 32'(op), 32'(ein[6:0]));
            check($sformatf("v%0d_rd", i), 32'(rd), 32'(ein[11:7]));
            check($sformatf("v%0d_funct3", i), 32'(funct3), 32'(ein[14:12]));
            check($sformatf("v%0d_rs1", i), 32'(rs1), 32'(ein[19:15]));
            check($sformatf("v%0d_rs2", i), 32'(rs2), 32'(ein[24:20]));
            check($sformatf("v%0d_f7b5", i), 32'(funct7b5), 32'(ein[30]));
            if (i == 0) check("v0_rd_hand", 32'(rd), 32'd1);
            if (i == 4) begin
                check("v4_op_hand", 32'(op), 32'h33);
                check("v4_rs1_hand", 32'(rs1), 32'd1);
                check("v4_rs2_hand", 32'(rs2), 32'd2);
                check("v4_f7b5_hand", 32'(funct7b5), 32'd1);
            end
        end

        // Recovery: reset while halted, enables asserted, then fetch from 0.
        rst = 1'b1;
        drive(1, 1, 32'h22, 32'hffffffff, 32'h9);
        step();
        check("rec_halted", 32'(halted), 32'h0);
        check("rec_pc", pc, 32'h0);
        check("rec_instr", instr, 32'h13);
        check("rec_fault_pc", fault_pc, 32'h0);
        check("rec_cycle", cycle_cnt, 32'h0);
        rst = 1'b0;
        drive(1, 1, 32'h4, 32'h00500093, 32'h0);
        step();
        check("rec_fetch_pc", pc, 32'h4);
        check("rec_fetch_old_pc", old_pc, 32'h0);
        check("rec_fetch_instr", instr, 32'h00500093);
        check("rec_fetch_cnt", fetch_cnt, 32'h1);
        check("rec_cycle1", cycle_cnt, 32'h1);

        // Counter wrap on the 4-bit instance: 16 IR loads then one idle cycle.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 32'h0, 32'(i), 32'h0);
            step();
        end
        check("wrap16_cycle4", 32'(cycle_cnt4), 32'h0);
        check("wrap16_fetch4", 32'(fetch_cnt4), 32'h0);
        drive(0, 0, 32'h0, 32'h0, 32'h0);
        step();
        check("wrap17_cycle4", 32'(cycle_cnt4), 32'h1);
        check("wrap17_fetch4", 32'(fetch_cnt4), 32'h0);
        check("wrap17_cycle32", cycle_cnt, 32'd17);
        check("wrap17_fetch32", fetch_cnt, 32'd16);
        check("wrap17_instr", instr, 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
